// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

    localparam int unsigned ALU_OP_W     = 5;
    localparam int unsigned STATUS_Z_BIT = 2;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned XLEN         = 32;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_t;

    // Registered control bundle; br_eval marks the branch EXEC cycle where PCSrc follows Z.
    typedef struct packed {
        logic    reg_write;
        logic    br_eval;
        logic    alu_src;
        alu_op_t alu_op;
        logic    write;
        logic    mem_to_reg;
        logic    pc_en;
        logic    halted;
    } ctrl_out_t;

    // funct3 -> ALU op for R/I arithmetic; alt selects SUB/SRA.
    function automatic alu_op_t arith_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/ROM signal bundle. CTRL_PERF_CNT_EN adds the perf counters.
interface multicycle_ctrl_if;
    import ctrl_pkg::*;

    logic [XLEN-1:0]     inst;
    logic [3:0]          status;
    logic                RegWrite;
    logic                PCSrc;
    logic                ALUSrc;
    logic [ALU_OP_W-1:0] ALU_operation;
    logic                write;
    logic                MemtoReg;
    logic                pc_en;
    logic                halted;
    logic [STATE_W-1:0]  state_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]         cycle_cnt;
    logic [31:0]         instret_cnt;
`endif

`ifdef CTRL_PERF_CNT_EN
    modport master (input inst, status,
                    output RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg,
                           pc_en, halted, state_o, cycle_cnt, instret_cnt);
    modport slave  (output inst, status,
                    input  RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg,
                           pc_en, halted, state_o, cycle_cnt, instret_cnt);
`else
    modport master (input inst, status,
                    output RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg,
                           pc_en, halted, state_o);
    modport slave  (output inst, status,
                    input  RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg,
                           pc_en, halted, state_o);
`endif

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct decode to ALU operation, flagging unsupported encodings.
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output alu_op_t    alu_op_c,
    output logic       illegal_c
);

    always_comb begin
        alu_op_c  = ALU_ADD;
        illegal_c = 1'b0;
        case (opcode)
            OP_R:      alu_op_c = arith_op(funct3, funct7_b5);
            // addi has no subtract form; bit 30 is immediate data there
            OP_I:      alu_op_c = arith_op(funct3, funct7_b5 && (funct3 != 3'b000));
            OP_LOAD,
            OP_STORE: begin
                alu_op_c  = ALU_ADD;
                illegal_c = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                alu_op_c  = ALU_SUB;
                illegal_c = (funct3[2:1] != 2'b00);
            end
            default:   illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath controls.
// Define CTRL_PERF_CNT_EN to add cycle_cnt/instret_cnt.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] ir_q, ir_d;
    ctrl_out_t       out_q, out_d;
    alu_op_t         alu_op_c;
    logic            illegal_c;
    logic            is_r, is_load, is_store, is_branch, rd_nz;
    logic            unused_bits;

    alu_op_decoder u_dec (
        .opcode    (ir_q[6:0]),
        .funct3    (ir_q[14:12]),
        .funct7_b5 (ir_q[30]),
        .alu_op_c  (alu_op_c),
        .illegal_c (illegal_c)
    );

    assign is_r      = (ir_q[6:0] == OP_R);
    assign is_load   = (ir_q[6:0] == OP_LOAD);
    assign is_store  = (ir_q[6:0] == OP_STORE);
    assign is_branch = (ir_q[6:0] == OP_BRANCH);
    assign rd_nz     = (ir_q[11:7] != 5'd0);

    // Next state, and the control word for the state being entered
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        out_d   = '0;
        case (state_q)
            FETCH: begin
                ir_d    = bus.inst;
                state_d = DECODE;
            end
            DECODE:  state_d = illegal_c ? HALT : EXEC;
            EXEC:    state_d = is_branch ? FETCH : ((is_load || is_store) ? MEM : WB);
            MEM:     state_d = is_store ? FETCH : WB;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase

        case (state_d)
            EXEC: begin
                out_d.alu_op  = alu_op_c;
                out_d.alu_src = !(is_r || is_branch);
                out_d.pc_en   = is_branch;
                out_d.br_eval = is_branch;
            end
            MEM: begin
                out_d.alu_op  = alu_op_c;
                out_d.alu_src = 1'b1;
                out_d.write   = is_store;
                out_d.pc_en   = is_store;
            end
            WB: begin
                out_d.alu_op     = alu_op_c;
                out_d.alu_src    = !is_r;
                out_d.reg_write  = rd_nz;
                out_d.mem_to_reg = !is_load;
                out_d.pc_en      = 1'b1;
            end
            HALT:    out_d.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
        end
    end

    assign bus.RegWrite      = out_q.reg_write;
    assign bus.ALUSrc        = out_q.alu_src;
    assign bus.ALU_operation = out_q.alu_op;
    assign bus.write         = out_q.write;
    assign bus.MemtoReg      = out_q.mem_to_reg;
    assign bus.pc_en         = out_q.pc_en;
    assign bus.halted        = out_q.halted;
    assign bus.state_o       = state_q;
    // Branch compare result only exists while the ALU runs SUB in EXEC
    assign bus.PCSrc         = out_q.br_eval & (bus.status[STATUS_Z_BIT] ^ ir_q[12]);

    assign unused_bits = ^{ir_q[31], ir_q[29:15], bus.status};

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != HALT) cycle_q <= cycle_q + 32'd1;
            if (out_q.pc_en)     instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, random vs. instruction-level model, corner sequences.
module tb_multicycle_ctrl;

    localparam int Z_BIT = 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observable per-cycle outputs
    typedef struct packed {
        logic [2:0] st;
        logic       rw;
        logic       pcsrc;
        logic       src;
        logic [4:0] alu;
        logic       wr;
        logic       m2r;
        logic       pce;
        logic       hlt;
    } cyc_t;

    // Per-instruction summary gathered from the outputs
    typedef struct packed {
        int         lat;
        logic [4:0] alu;
        logic       src;
        logic       held;
        logic       m2r;
        logic       pcsrc;
        int         rw_n;
        int         wr_n;
    } obs_t;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  status;
        int          lat;
        logic [4:0]  alu;
        logic        src;
        int          rw_n;
        int          wr_n;
        logic        m2r;
        logic        pcsrc;
    } vec_t;

    cyc_t trace[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic cyc_t sample();
        cyc_t s;
        s.st    = bus.state_o;
        s.rw    = bus.RegWrite;
        s.pcsrc = bus.PCSrc;
        s.src   = bus.ALUSrc;
        s.alu   = bus.ALU_operation;
        s.wr    = bus.write;
        s.m2r   = bus.MemtoReg;
        s.pce   = bus.pc_en;
        s.hlt   = bus.halted;
        return s;
    endfunction

    // Instruction-level reference: expected outputs for every cycle of one instruction
    task automatic build_trace(input logic [31:0] in, input logic [3:0] st, input int halt_cycles);
        int unsigned base_op [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        logic [6:0] op;
        logic [2:0] f3;
        logic       alt;
        logic       legal;
        cyc_t       e;
        op    = in[6:0];
        f3    = in[14:12];
        alt   = in[30];
        legal = (op == 7'h33) || (op == 7'h13) ||
                ((op == 7'h03 || op == 7'h23) && f3 == 3'd2) ||
                (op == 7'h63 && f3 < 3'd2);
        trace.delete();
        e = '0;
        trace.push_back(e);
        e.st = 3'd1;
        trace.push_back(e);
        if (!legal) begin
            e.st  = 3'd5;
            e.hlt = 1'b1;
            repeat (halt_cycles) trace.push_back(e);
            return;
        end
        e.st = 3'd2;
        if (op == 7'h33 || op == 7'h13) begin
            e.alu = 5'(base_op[f3]);
            if (alt && f3 == 3'd5) e.alu = 5'd7;
            if (alt && f3 == 3'd0 && op == 7'h33) e.alu = 5'd1;
        end else if (op == 7'h63) begin
            e.alu = 5'd1;
        end
        e.src = (op == 7'h13 || op == 7'h03 || op == 7'h23);
        if (op == 7'h63) begin
            e.pce   = 1'b1;
            e.pcsrc = st[Z_BIT] ^ f3[0];
            trace.push_back(e);
            return;
        end
        trace.push_back(e);
        if (op == 7'h03 || op == 7'h23) begin
            e.st  = 3'd3;
            e.wr  = (op == 7'h23);
            e.pce = (op == 7'h23);
            trace.push_back(e);
            if (op == 7'h23) return;
        end
        e.st  = 3'd4;
        e.wr  = 1'b0;
        e.rw  = (in[11:7] != 5'd0);
        e.m2r = (op != 7'h03);
        e.pce = 1'b1;
        trace.push_back(e);
    endtask

    // Drive one instruction from its FETCH cycle and compare every cycle against the model
    task automatic run_trace(input string nm, input logic [31:0] in, input logic [3:0] st);
        bus.inst   = in;
        bus.status = st;
        build_trace(in, st, 21);
        for (int k = 0; k < trace.size(); k++) begin
            chk($sformatf("%s.c%0d", nm, k), {17'd0, sample()}, {17'd0, trace[k]});
            @(negedge clk);
        end
    endtask

    task automatic run_obs(input logic [31:0] in, input logic [3:0] st, output obs_t o);
        bus.inst   = in;
        bus.status = st;
        o      = '0;
        o.held = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                o.alu = bus.ALU_operation;
                o.src = bus.ALUSrc;
            end else if (c > 2 && (bus.ALU_operation != o.alu || bus.ALUSrc != o.src)) begin
                o.held = 1'b0;
            end
            o.rw_n += int'(bus.RegWrite);
            o.wr_n += int'(bus.write);
            if (bus.pc_en) begin
                o.lat   = c + 1;
                o.m2r   = bus.MemtoReg;
                o.pcsrc = bus.PCSrc;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [15];
        obs_t        o;
        logic [6:0]  ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        logic [31:0] r;
        logic [3:0]  rs;
        n_cmp  = 0;
        n_fail = 0;

        //          inst          status lat alu  src rw wr m2r pcsrc
        vt[0]  = '{32'h00500093, 4'hF, 4, 5'd0, 1, 1, 0, 1, 0};  // addi x1,x0,5
        vt[1]  = '{32'h002081B3, 4'hF, 4, 5'd0, 0, 1, 0, 1, 0};  // add
        vt[2]  = '{32'h402081B3, 4'hF, 4, 5'd1, 0, 1, 0, 1, 0};  // sub
        vt[3]  = '{32'h0080A283, 4'hF, 5, 5'd0, 1, 1, 0, 0, 0};  // lw
        vt[4]  = '{32'h0050A623, 4'hF, 4, 5'd0, 1, 0, 1, 0, 0};  // sw
        vt[5]  = '{32'h00208463, 4'h4, 3, 5'd1, 0, 0, 0, 0, 1};  // beq taken
        vt[6]  = '{32'h00208463, 4'h0, 3, 5'd1, 0, 0, 0, 0, 0};  // beq not taken
        vt[7]  = '{32'h00209463, 4'h4, 3, 5'd1, 0, 0, 0, 0, 0};  // bne not taken
        vt[8]  = '{32'h00209463, 4'hB, 3, 5'd1, 0, 0, 0, 0, 1};  // bne taken
        vt[9]  = '{32'h00000013, 4'h0, 4, 5'd0, 1, 0, 0, 1, 0};  // nop, rd=x0
        vt[10] = '{32'h4030D093, 4'h0, 4, 5'd7, 1, 1, 0, 1, 0};  // srai
        vt[11] = '{32'hC0000113, 4'h0, 4, 5'd0, 1, 1, 0, 1, 0};  // addi neg imm, bit30 set
        vt[12] = '{32'h0020B1B3, 4'h0, 4, 5'd9, 0, 1, 0, 1, 0};  // sltu
        vt[13] = '{32'h0020F1B3, 4'h0, 4, 5'd2, 0, 1, 0, 1, 0};  // and
        vt[14] = '{32'h4020D1B3, 4'h0, 4, 5'd7, 0, 1, 0, 1, 0};  // sra

        bus.inst   = '0;
        bus.status = '0;
        reset      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.state", {29'd0, bus.state_o}, 32'd0);
        chk("reset.outs", {17'd0, sample()}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_obs(vt[i].inst, vt[i].status, o);
            chk($sformatf("v%0d.lat", i),   o.lat,          vt[i].lat);
            chk($sformatf("v%0d.alu", i),   {27'd0, o.alu}, {27'd0, vt[i].alu});
            chk($sformatf("v%0d.src", i),   {31'd0, o.src}, {31'd0, vt[i].src});
            chk($sformatf("v%0d.rw", i),    o.rw_n,         vt[i].rw_n);
            chk($sformatf("v%0d.wr", i),    o.wr_n,         vt[i].wr_n);
            chk($sformatf("v%0d.m2r", i),   {31'd0, o.m2r}, {31'd0, vt[i].m2r});
            chk($sformatf("v%0d.pcsrc", i), {31'd0, o.pcsrc}, {31'd0, vt[i].pcsrc});
            chk($sformatf("v%0d.held", i),  {31'd0, o.held}, 32'd1);
        end

        for (int n = 0; n < 250; n++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(4, 0)];
            if (r[6:0] == 7'b0000011 || r[6:0] == 7'b0100011) r[14:12] = 3'b010;
            if (r[6:0] == 7'b1100011) r[14:13] = 2'b00;
            rs = 4'($urandom());
            run_trace($sformatf("rnd%0d", n), r, rs);
        end

        // Illegal opcode: sticky HALT until reset
        run_trace("halt", 32'hFFFFFFFF, 4'h0);
        reset = 1'b0;
        #1;
        chk("halt.rst.state", {29'd0, bus.state_o}, 32'd0);
        chk("halt.rst.halted", {31'd0, bus.halted}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_trace("post_halt", 32'h00500093, 4'h0);

        // Reset asserted during MEM of a store
        bus.inst   = 32'h0050A623;
        bus.status = 4'h0;
        build_trace(32'h0050A623, 4'h0, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sw_abort.c%0d", k), {17'd0, sample()}, {17'd0, trace[k]});
            if (k < 3) @(negedge clk);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("sw_abort.write", {31'd0, bus.write}, 32'd0);
        chk("sw_abort.pc_en", {31'd0, bus.pc_en}, 32'd0);
        chk("sw_abort.state", {29'd0, bus.state_o}, 32'd0);
        @(negedge clk);
        bus.inst = 32'h00000013;
        reset    = 1'b1;
        run_trace("after_abort", 32'h00000013, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
